// File: rtl/pc_redirect_unit_pkg.sv
// pc_redirect_unit_pkg: shared constants, FSM encoding and branch-type codes for the IF-stage PC unit
package pc_redirect_unit_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;
  localparam logic [31:0] NOP = 32'h0000_0000;
  typedef enum logic {RUN = 1'b0, PEND = 1'b1} state_t;
  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BEQ     = 3'b001,
    BNE     = 3'b010,
    BLEZ    = 3'b011,
    BGTZ    = 3'b100,
    BLTZ    = 3'b101
  } br_type_t;
  function automatic logic [31:0] align4(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/pc_redirect_unit_if.sv
// pc_redirect_unit_if: ID/hazard/imem side (master) versus PC unit side (slave)
interface pc_redirect_unit_if;
  logic        stall_i;
  logic        branch_i;
  logic        jump_i;
  logic        jr_i;
  logic [31:0] id_pc_plus4_i;
  logic [31:0] id_imm32_i;
  logic [31:0] jump_target_i;
  logic [31:0] jr_target_i;
  logic        if_ready_i;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        ifid_write_o;
  logic        ifid_flush_o;
  logic        redirect_pending_o;
  modport master (
    output stall_i, branch_i, jump_i, jr_i, id_pc_plus4_i, id_imm32_i, jump_target_i, jr_target_i, if_ready_i,
    input  pc_o, pc_plus4_o, ifid_write_o, ifid_flush_o, redirect_pending_o
  );
  modport slave (
    input  stall_i, branch_i, jump_i, jr_i, id_pc_plus4_i, id_imm32_i, jump_target_i, jr_target_i, if_ready_i,
    output pc_o, pc_plus4_o, ifid_write_o, ifid_flush_o, redirect_pending_o
  );
endinterface

// File: rtl/pc_redirect_unit_next_pc_sel.sv
// next_pc_sel: redirect target with branch > jr > jump priority, word aligned
module next_pc_sel
  import pc_redirect_unit_pkg::*;
(
  input  logic        branch,
  input  logic        jr,
  input  logic [31:0] id_pc_plus4,
  input  logic [31:0] id_imm32,
  input  logic [31:0] jump_target,
  input  logic [31:0] jr_target,
  output logic [31:0] target
);
  logic [31:0] branch_target;
  assign branch_target = id_pc_plus4 + (id_imm32 << 2);
  assign target = align4(branch ? branch_target : jr ? jr_target : jump_target);
endmodule

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: fetch PC register and redirect FSM that parks targets while imem is busy
module pc_redirect_unit
  import pc_redirect_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input logic             clk,
  input logic             reset,
  pc_redirect_unit_if.slave bus
);
  state_t      state;
  logic [31:0] pc;
  logic [31:0] pending_pc;
  logic [31:0] target;
  logic        redirect;
  assign redirect = ~bus.stall_i & (bus.branch_i | bus.jr_i | bus.jump_i);
  next_pc_sel u_sel (
    .branch      (bus.branch_i),
    .jr          (bus.jr_i),
    .id_pc_plus4 (bus.id_pc_plus4_i),
    .id_imm32    (bus.id_imm32_i),
    .jump_target (bus.jump_target_i),
    .jr_target   (bus.jr_target_i),
    .target      (target)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= RESET_PC;
      state      <= RUN;
      pending_pc <= '0;
    end else if (state == RUN) begin
      if (redirect && bus.if_ready_i) pc <= target;
      else if (redirect) begin
        pending_pc <= target;
        state      <= PEND;
      end else if (!bus.stall_i && bus.if_ready_i) pc <= pc + 32'd4;
    end else if (bus.if_ready_i) begin
      pc    <= pending_pc;
      state <= RUN;
    end
  end
  // RUN: stall holds, redirect or missing word flushes, otherwise write; PEND: flush unless stalled
  assign bus.ifid_write_o       = ~reset & (state == RUN) & ~bus.stall_i & ~redirect & bus.if_ready_i;
  assign bus.ifid_flush_o       = reset | (~bus.stall_i & ((state == PEND) | redirect | ~bus.if_ready_i));
  assign bus.redirect_pending_o = ~reset & (state == PEND);
  assign bus.pc_o               = pc;
  assign bus.pc_plus4_o         = pc + 32'd4;
endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit: scoreboard bench, expectations queued per driven cycle and checked at negedge
module tb_pc_redirect_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pc_redirect_unit_if b ();
  pc_redirect_unit #(.RESET_PC(32'h0040_0000)) dut (.clk(clk), .reset(reset), .bus(b));

  typedef struct {
    string       nm;
    logic [31:0] pc;
    logic        wr;
    logic        fl;
    logic        pd;
  } exp_t;
  exp_t sb[$];
  int passed = 0;
  int total = 0;
  int multi_cnt = 0;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      total++;
      if ({b.pc_o, b.pc_plus4_o, b.ifid_write_o, b.ifid_flush_o, b.redirect_pending_o} !==
          {e.pc, e.pc + 32'd4, e.wr, e.fl, e.pd})
        $display("FAIL %s: pc=%h p4=%h wr=%b fl=%b pd=%b, required pc=%h p4=%h wr=%b fl=%b pd=%b",
                 e.nm, b.pc_o, b.pc_plus4_o, b.ifid_write_o, b.ifid_flush_o, b.redirect_pending_o,
                 e.pc, e.pc + 32'd4, e.wr, e.fl, e.pd);
      else passed++;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      assert ($onehot0({b.branch_i, b.jr_i, b.jump_i}))
      else begin
        multi_cnt++;
        $warning("protocol: more than one redirect request in one cycle");
      end
      assert (!(b.redirect_pending_o && (b.branch_i || b.jr_i || b.jump_i)))
      else $error("protocol: redirect request while a redirect is parked");
    end
  end

  task automatic drive(input string nm, input logic st, input logic br, input logic jr, input logic jp,
                       input logic rdy, input logic [31:0] p4, input logic [31:0] imm,
                       input logic [31:0] jt, input logic [31:0] jrt, input logic [31:0] epc,
                       input logic ewr, input logic efl, input logic epd);
    b.stall_i = st;
    b.branch_i = br;
    b.jr_i = jr;
    b.jump_i = jp;
    b.if_ready_i = rdy;
    b.id_pc_plus4_i = p4;
    b.id_imm32_i = imm;
    b.jump_target_i = jt;
    b.jr_target_i = jrt;
    sb.push_back('{nm, epc, ewr, efl, epd});
    @(posedge clk);
    #1;
  endtask

  task automatic seq(input string nm, input logic [31:0] epc);
    drive(nm, 0, 0, 0, 0, 1, 0, 0, 0, 0, epc, 1, 0, 0);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(posedge clk);
    #1;
    drive("reset", 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h0040_0000, 0, 1, 0);
    reset = 1'b0;
  endtask

  task automatic test_sequential;
    seq("seq0", 32'h0040_0000);
    seq("seq1", 32'h0040_0004);
    seq("seq2", 32'h0040_0008);
    seq("seq3", 32'h0040_000C);
  endtask

  task automatic test_branch;
    drive("br_flush", 0, 1, 0, 0, 1, 32'h0040_000C, 32'hFFFF_FFFD, 0, 0, 32'h0040_0010, 0, 1, 0);
    seq("br_target", 32'h0040_0000);
  endtask

  task automatic test_pend_jr;
    drive("jr_park", 0, 0, 1, 0, 0, 0, 0, 0, 32'h0040_0023, 32'h0040_0004, 0, 1, 0);
    drive("jr_wait", 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0004, 0, 1, 1);
    drive("jr_done", 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h0040_0004, 0, 1, 1);
    seq("jr_target", 32'h0040_0020);
  endtask

  task automatic test_stall;
    drive("stall_hold", 1, 1, 0, 0, 1, 32'h0040_0100, 32'h4, 0, 0, 32'h0040_0024, 0, 0, 0);
    drive("stall_release", 0, 1, 0, 0, 1, 32'h0040_0100, 32'h4, 0, 0, 32'h0040_0024, 0, 1, 0);
    seq("stall_target", 32'h0040_0110);
  endtask

  task automatic test_pend_reset;
    drive("rst_park", 0, 0, 0, 1, 0, 0, 0, 32'h0050_0000, 0, 32'h0040_0114, 0, 1, 0);
    reset = 1'b1;
    drive("rst_in_pend", 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0114, 0, 1, 0);
    reset = 1'b0;
    seq("rst_pc", 32'h0040_0000);
    seq("rst_no_park", 32'h0040_0004);
  endtask

  task automatic test_pend_stall;
    drive("ps_park", 0, 0, 0, 1, 0, 0, 0, 32'h0040_0041, 0, 32'h0040_0008, 0, 1, 0);
    drive("ps_stall_wait", 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0008, 0, 0, 1);
    drive("ps_stall_done", 1, 0, 0, 0, 1, 0, 0, 0, 0, 32'h0040_0008, 0, 0, 1);
    seq("ps_target", 32'h0040_0040);
  endtask

  task automatic test_wrap_priority;
    drive("wrap_jr", 0, 0, 1, 0, 1, 0, 0, 0, 32'hFFFF_FFFF, 32'h0040_0044, 0, 1, 0);
    seq("wrap_top", 32'hFFFF_FFFC);
    drive("prio_flush", 0, 1, 0, 1, 1, 32'h0000_0100, 32'h1, 32'h0000_2000, 0, 32'h0000_0000, 0, 1, 0);
    seq("prio_target", 32'h0000_0104);
    total++;
    if (multi_cnt !== 1) $display("FAIL multi_req_flag: count=%0d, required 1", multi_cnt);
    else passed++;
  endtask

  initial begin
    b.stall_i = 0;
    b.branch_i = 0;
    b.jr_i = 0;
    b.jump_i = 0;
    b.if_ready_i = 0;
    b.id_pc_plus4_i = 0;
    b.id_imm32_i = 0;
    b.jump_target_i = 0;
    b.jr_target_i = 0;
    test_reset();
    test_sequential();
    test_branch();
    test_pend_jr();
    test_stall();
    test_pend_reset();
    test_pend_stall();
    test_wrap_priority();
    drive("idle_bubble", 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0108, 0, 1, 0);
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    #1;
    total++;
    if (sb.size() !== 0) $display("FAIL scoreboard_drain: left=%0d, required 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
